// File: rtl/panel_switches.sv
// Front-panel switch conditioner: synchronises and debounces the five active-low
// panel buttons and turns them into single-cycle command pulses for the CPU.
module panel_switches #(
    parameter logic [15:0] DB_COUNT      = 16'd50000,
    parameter logic [23:0] REPEAT_DELAY  = 24'd6000000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1200000
) (
    input  logic       SYSCLK,
    input  logic       RESETn,
    input  logic       pin_CLEAR,
    input  logic       pin_RUN,
    input  logic       pin_HALT,
    input  logic       pin_STEPM,
    input  logic       pin_STEPI,
    output logic       sw_CLEAR,
    output logic       sw_RUN,
    output logic       sw_HALT,
    output logic       sw_STEPM,
    output logic       sw_STEPI,
    output logic [4:0] held
);

    localparam int CLR = 4;
    localparam int RUN = 3;
    localparam int HLT = 2;
    localparam int STM = 1;
    localparam int STI = 0;

    logic [4:0]  pins;
    logic [4:0]  sync1;
    logic [4:0]  sync2;
    logic [4:0]  db;
    logic [4:0]  db_d;
    logic [4:0]  press;
    logic [15:0] cnt [5];
    logic [1:0]  rpt_on;
    logic [1:0]  rep_evt;
    logic [23:0] tmr [2];
    logic        lock;
    logic        nxt_clear;
    logic        nxt_run;
    logic        nxt_halt;
    logic        nxt_stepm;
    logic        nxt_stepi;

    assign pins  = {pin_CLEAR, pin_RUN, pin_HALT, pin_STEPM, pin_STEPI};
    assign held  = db;
    assign press = db & ~db_d;
    assign lock  = db[CLR];

    // Synchroniser stores the inverted pin so that reset value 0 means "released".
    always_ff @(posedge SYSCLK) begin
        if (!RESETn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= ~pins;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!RESETn) begin
            db   <= '0;
            db_d <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            db_d <= db;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_COUNT - 16'd1) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    // Repeat timers for STEPI (index 0) and STEPM (index 1); they share bit
    // positions with db so a release or CLEAR lockout idles them at once.
    always_comb begin
        rep_evt = '0;
        for (int j = 0; j < 2; j++)
            rep_evt[j] = rpt_on[j] & db[j] & ~lock & (tmr[j] == '0);
    end

    always_ff @(posedge SYSCLK) begin
        for (int j = 0; j < 2; j++) begin
            if (!RESETn || lock || !db[j]) begin
                rpt_on[j] <= 1'b0;
                tmr[j]    <= '0;
            end else if (press[j]) begin
                rpt_on[j] <= (REPEAT_DELAY != 24'd0);
                tmr[j]    <= REPEAT_DELAY;
            end else if (rpt_on[j]) begin
                tmr[j] <= (tmr[j] == '0) ? REPEAT_PERIOD : tmr[j] - 24'd1;
            end
        end
    end

    // A CLEAR event implies lock, so gating on lock also suppresses RUN/STEP on it.
    always_comb begin
        nxt_clear = 1'b0;
        nxt_run   = 1'b0;
        nxt_halt  = 1'b0;
        nxt_stepm = 1'b0;
        nxt_stepi = 1'b0;
        nxt_clear = press[CLR];
        nxt_halt  = press[HLT] & ~press[CLR];
        nxt_run   = press[RUN] & ~lock & ~press[HLT];
        nxt_stepm = (press[STM] | rep_evt[1]) & ~lock;
        nxt_stepi = (press[STI] | rep_evt[0]) & ~lock;
    end

    always_ff @(posedge SYSCLK) begin
        if (!RESETn) begin
            sw_CLEAR <= 1'b0;
            sw_RUN   <= 1'b0;
            sw_HALT  <= 1'b0;
            sw_STEPM <= 1'b0;
            sw_STEPI <= 1'b0;
        end else begin
            sw_CLEAR <= nxt_clear;
            sw_RUN   <= nxt_run;
            sw_HALT  <= nxt_halt;
            sw_STEPM <= nxt_stepm;
            sw_STEPI <= nxt_stepi;
        end
    end

endmodule

// File: tb/tb_panel_switches.sv
// Directed bench for panel_switches: logs every sw_* pulse with its edge number
// and compares the log against hand-computed pulse times per scenario.
module tb_panel_switches;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pin_clear, pin_run, pin_halt, pin_stepm, pin_stepi;
    logic       sw_clear, sw_run, sw_halt, sw_stepm, sw_stepi;
    logic [4:0] held;

    panel_switches #(
        .DB_COUNT     (16'd4),
        .REPEAT_DELAY (24'd20),
        .REPEAT_PERIOD(24'd8)
    ) dut (
        .SYSCLK   (clk),
        .RESETn   (rst_n),
        .pin_CLEAR(pin_clear),
        .pin_RUN  (pin_run),
        .pin_HALT (pin_halt),
        .pin_STEPM(pin_stepm),
        .pin_STEPI(pin_stepi),
        .sw_CLEAR (sw_clear),
        .sw_RUN   (sw_run),
        .sw_HALT  (sw_halt),
        .sw_STEPM (sw_stepm),
        .sw_STEPI (sw_stepi),
        .held     (held)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int cyc;
    } ev_t;

    ev_t         evq[$];
    logic [31:0] exp_q[$];
    int          cyc = 0;
    int          t0 = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    // Channel numbers follow the held bit order.
    always @(negedge clk) begin
        if (sw_clear) evq.push_back('{4, cyc});
        if (sw_run)   evq.push_back('{3, cyc});
        if (sw_halt)  evq.push_back('{2, cyc});
        if (sw_stepm) evq.push_back('{1, cyc});
        if (sw_stepi) evq.push_back('{0, cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
    endtask

    // Returns #1 after edge t0+rel.
    task automatic wait_rel(input int rel);
        if (cyc < t0 + rel) step(t0 + rel - cyc);
        #1;
    endtask

    task automatic start_test();
        step(1);
        t0 = cyc;
        evq.delete();
        #1;
    endtask

    // Compares logged pulses of one channel (relative to t0) against exp_q.
    task automatic check_chan(input string tag, input int ch);
        int n = 0;
        foreach (evq[k]) begin
            if (evq[k].ch == ch) begin
                if (n < exp_q.size())
                    check($sformatf("%s_pulse%0d", tag, n), evq[k].cyc - t0, exp_q[n]);
                n++;
            end
        end
        check({tag, "_count"}, n, exp_q.size());
        exp_q.delete();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_sw"}, {27'd0, sw_clear, sw_run, sw_halt, sw_stepm, sw_stepi}, 32'd0);
        check({tag, "_held"}, {27'd0, held}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        {pin_clear, pin_run, pin_halt, pin_stepm, pin_stepi} = 5'b11111;
        step(3);
        #1;
        check_quiet("reset");
        rst_n = 1'b1;
        step(5);
        #1;
        check_quiet("idle");

        // 1: clean RUN press
        start_test();
        pin_run = 1'b0;
        wait_rel(5);
        check("t1_held_e5", {31'd0, held[3]}, 32'd0);
        wait_rel(6);
        check("t1_held_e6", {31'd0, held[3]}, 32'd1);
        wait_rel(40);
        pin_run = 1'b1;
        wait_rel(45);
        check("t1_rel_e45", {31'd0, held[3]}, 32'd1);
        wait_rel(46);
        check("t1_rel_e46", {31'd0, held[3]}, 32'd0);
        step(8);
        exp_q.push_back(7);
        check_chan("t1_run", 3);
        for (int c = 0; c < 5; c++) if (c != 3) check_chan($sformatf("t1_ch%0d", c), c);

        // 2: HALT bounce with 3-cycle lows, then a steady press
        start_test();
        for (int k = 0; k < 7; k++) begin
            pin_halt = 1'b0;
            step(3);
            #1;
            pin_halt = 1'b1;
            step(3);
            #1;
        end
        check("t2_bounce_held", {31'd0, held[2]}, 32'd0);
        check("t2_bounce_pulses", evq.size(), 0);
        t0 = cyc;
        evq.delete();
        pin_halt = 1'b0;
        wait_rel(25);
        pin_halt = 1'b1;
        step(12);
        exp_q.push_back(7);
        check_chan("t2_halt", 2);

        // 3: STEPI auto-repeat; release at 57 is the latest that avoids the pulse due at 64
        start_test();
        pin_stepi = 1'b0;
        wait_rel(57);
        pin_stepi = 1'b1;
        wait_rel(80);
        exp_q.push_back(7);
        exp_q.push_back(28);
        exp_q.push_back(37);
        exp_q.push_back(46);
        exp_q.push_back(55);
        check_chan("t3_stepi", 0);
        check("t3_held", {27'd0, held}, 32'd0);

        // 4: CLEAR lockout of STEPM, HALT still passes
        start_test();
        pin_clear = 1'b0;
        wait_rel(10);
        pin_stepm = 1'b0;
        wait_rel(12);
        pin_halt = 1'b0;
        wait_rel(20);
        check("t4_held", {27'd0, held}, 32'b10110);
        wait_rel(50);
        {pin_clear, pin_halt, pin_stepm} = 3'b111;
        wait_rel(65);
        exp_q.push_back(7);
        check_chan("t4_clear", 4);
        exp_q.push_back(19);
        check_chan("t4_halt", 2);
        check_chan("t4_stepm", 1);
        check_chan("t4_run", 3);

        // 5: RUN and HALT together
        start_test();
        pin_run  = 1'b0;
        pin_halt = 1'b0;
        wait_rel(20);
        pin_run  = 1'b1;
        pin_halt = 1'b1;
        wait_rel(35);
        exp_q.push_back(7);
        check_chan("t5_halt", 2);
        check_chan("t5_run", 3);

        // 6: reset while STEPI held; last reset edge is 17
        start_test();
        pin_stepi = 1'b0;
        wait_rel(15);
        rst_n = 1'b0;
        wait_rel(16);
        check_quiet("t6_rst16");
        wait_rel(17);
        check_quiet("t6_rst17");
        rst_n = 1'b1;
        wait_rel(50);
        pin_stepi = 1'b1;
        wait_rel(70);
        exp_q.push_back(7);
        exp_q.push_back(24);
        exp_q.push_back(45);
        exp_q.push_back(54);
        check_chan("t6_stepi", 0);
        check_quiet("t6_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
